// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store path: access types, funct3 values and
// the memory-port FSM state type.
package lsu_pkg;

  localparam logic [1:0] LD_W   = 2'b00;
  localparam logic [1:0] LD_BU  = 2'b01;
  localparam logic [1:0] LD_B   = 2'b10;
  localparam logic [1:0] LD_ILL = 2'b11;

  localparam logic ST_W = 1'b0;
  localparam logic ST_B = 1'b1;

  // funct3 values the decoder maps onto the types above
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] store_strb(input logic st_type, input logic [1:0] off);
    logic [3:0] strb;
    strb = 4'b1111;
    if (st_type == ST_B) strb = 4'b0001 << off;
    return strb;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte out of a memory word and zero/sign-extends it,
// or passes the whole word through for word loads.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  load_type_i,
  output logic [31:0] rdata_o
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = mem_rdata_i[{byte_off_i, 3'b000} +: 8];
    rdata_o  = '0;
    case (load_type_i)
      LD_W:    rdata_o = mem_rdata_i;
      LD_BU:   rdata_o = {24'b0, sel_byte};
      LD_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory side of loads and stores: one access in flight over a
// request/grant/response port, with lane placement and load alignment.
//
//   state  | meaning
//   IDLE   | waiting for req_valid; accepts and fault-checks the access
//   REQ    | mem_req high, request fields held until mem_gnt
//   WAIT   | granted, waiting for mem_rvalid
//   DONE   | one-cycle rsp_valid (with fault / rdata), then IDLE
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          is_store,
  input  logic [1:0]    load_type,
  input  logic          store_type,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          rsp_valid,
  output logic [DW-1:0] rdata,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    state_q;
  logic          is_store_q;
  logic [1:0]    load_type_q;
  logic [1:0]    off_q;
  logic          rsp_valid_q;
  logic          fault_q;
  logic [DW-1:0] rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [3:0]    mem_wstrb_q;

  logic          acc_fault;
  logic [DW-1:0] st_wdata_d;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] rsp_data_d;

  always_comb begin
    if (is_store)
      acc_fault = (store_type == ST_W) && (addr[1:0] != 2'b00);
    else
      acc_fault = (load_type == LD_ILL) ||
                  ((load_type == LD_W) && (addr[1:0] != 2'b00));
  end

  assign st_wdata_d = (store_type == ST_B) ? {4{wdata[7:0]}} : wdata;

  load_align u_load_align (
    .mem_rdata_i (mem_rdata),
    .byte_off_i  (off_q),
    .load_type_i (load_type_q),
    .rdata_o     (ld_data)
  );

  // stores complete with zero result data
  assign rsp_data_d = is_store_q ? '0 : ld_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      load_type_q <= LD_W;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            is_store_q  <= is_store;
            load_type_q <= load_type;
            off_q       <= addr[1:0];
            if (acc_fault) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              fault_q     <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[AW-1:2], 2'b00};
              mem_wdata_q <= is_store ? st_wdata_d : '0;
              mem_wstrb_q <= is_store ? store_strb(store_type, addr[1:0]) : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            if (mem_rvalid) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rsp_data_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rsp_data_d;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // the acceptance cycle stalls the core before the FSM has moved
  assign busy = (state_q == S_REQ) || (state_q == S_WAIT) ||
                ((state_q == S_IDLE) && req_valid && !rst);

  assign rsp_valid = rsp_valid_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised bench for lsu_mem_port: the bench plays the memory and predicts
// each access's timeline, port fields and result from the access rules.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        is_store;
  logic [1:0]  load_type;
  logic        store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .is_store   (is_store),
    .load_type  (load_type),
    .store_type (store_type),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered just after a negedge in an IDLE cycle; returns at the negedge of
  // the IDLE cycle following DONE. g = REQ cycles without grant, rv = WAIT
  // cycles without rvalid, same = grant and rvalid together.
  task automatic do_access(input logic st, input logic [1:0] lt, input logic stt,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int g, input int rv, input logic same,
                           input logic [31:0] rd, input logic arm_in_done);
    logic        e_fault;
    logic [31:0] e_rdata, e_wdata, bsel;
    logic [3:0]  e_strb;
    int          rsp_n, gnt_n, rv_n;

    if (st) e_fault = (stt == 1'b0) && (a[1:0] != 2'b00);
    else    e_fault = (lt == 2'd3) || (lt == 2'd0 && a[1:0] != 2'b00);

    bsel = (rd >> (8 * a[1:0])) & 32'hFF;
    if (e_fault || st)   e_rdata = 32'h0;
    else if (lt == 2'd0) e_rdata = rd;
    else if (lt == 2'd1) e_rdata = bsel;
    else                 e_rdata = (bsel >= 32'd128) ? (bsel | 32'hFFFF_FF00) : bsel;

    e_strb  = (stt == 1'b0) ? 4'hF : 4'(1 << a[1:0]);
    e_wdata = (stt == 1'b0) ? wd : (wd & 32'hFF) * 32'h0101_0101;

    gnt_n = 1 + g;
    rv_n  = same ? gnt_n : gnt_n + 1 + rv;
    rsp_n = e_fault ? 1 : rv_n + 1;

    req_valid  = 1'b1;
    is_store   = st;
    load_type  = lt;
    store_type = stt;
    addr       = a;
    wdata      = wd;
    #1;
    chk("busy_accept", 32'(busy), 32'd1);

    for (int n = 1; n <= rsp_n; n++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      is_store   = 1'($urandom);
      addr       = $urandom;
      wdata      = $urandom;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!e_fault && n == gnt_n) mem_gnt = 1'b1;
      if (!e_fault && n == rv_n) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
      #1;
      chk("busy", 32'(busy), (n < rsp_n) ? 32'd1 : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), (n == rsp_n) ? 32'd1 : 32'd0);
      chk("mem_req", 32'(mem_req), (!e_fault && n <= gnt_n) ? 32'd1 : 32'd0);
      if (!e_fault && n <= gnt_n) begin
        chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("mem_we", 32'(mem_we), 32'(st));
        if (st) begin
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
          chk("mem_wdata", mem_wdata, e_wdata);
        end
      end
      if (n == rsp_n) begin
        chk("fault", 32'(fault), 32'(e_fault));
        chk("rdata", rdata, e_rdata);
      end
    end

    if (arm_in_done) begin
      req_valid = 1'b1;
      is_store  = 1'b0;
      load_type = 2'd3;
      #1;
      chk("busy_done_req", 32'(busy), 32'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("idle_after_done", 32'(rsp_valid | busy | mem_req), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    load_type  = 2'd0;
    store_type = 1'b0;
    addr       = '0;
    wdata      = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_access(1, 2'd0, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0);
    do_access(1, 2'd0, 1, 32'h203, 32'h0000_00A5, 0, 0, 0, 32'h0, 0);
    do_access(0, 2'd2, 0, 32'h302, 32'h0, 0, 0, 0, 32'h12F0_3456, 0);
    do_access(0, 2'd1, 0, 32'h302, 32'h0, 0, 1, 0, 32'h12F0_3456, 0);
    do_access(0, 2'd0, 0, 32'h300, 32'h0, 1, 0, 0, 32'h12F0_3456, 0);
    do_access(0, 2'd0, 0, 32'h401, 32'h0, 0, 0, 0, 32'h0, 0);
    do_access(0, 2'd3, 0, 32'h400, 32'h0, 0, 0, 0, 32'h0, 0);
    do_access(1, 2'd0, 0, 32'h402, 32'h1234_5678, 0, 0, 0, 32'h0, 0);
    do_access(0, 2'd0, 0, 32'h500, 32'h0, 5, 0, 0, 32'hCAFE_F00D, 0);
    do_access(0, 2'd2, 0, 32'h601, 32'h0, 0, 0, 1, 32'h0000_7F00, 1);

    // reset while in WAIT, then a stray rvalid
    req_valid = 1'b1; is_store = 1'b0; load_type = 2'd0; addr = 32'h700;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("wait_rst_busy", 32'(busy), 32'd0);
    chk("wait_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("wait_rst_req", 32'(mem_req), 32'd0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
      chk("late_rvalid_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // randomised accesses
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom)};
      do_access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
